// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and small decode helpers.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] funct3);
    return funct3[2] & funct3[1];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation; gives |x| when neg_i is the
// operand's sign, or applies the final result sign.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (W'(0) - val_i) : val_i;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fixed on exit.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iKill,
  output logic [XLEN-1:0] oResult,
  output logic            oValid,
  output logic            oBusy,
  output logic            oStall
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  state_e            state_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   opr_q, hi_q, lo_q, result_q;
  logic              neg_q, valid_q;
  logic [CW-1:0]     cnt_q;

  logic              sa, sb, neg_a, neg_b, start_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              fast, b_zero, sovf;
  logic [XLEN-1:0]   fast_res;

  logic [XLEN-1:0]   hi_d, lo_d;
  logic [XLEN:0]     sum, shifted;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   res_d;

  assign sa    = !(iFunct3 inside {F3_MULHU, F3_DIVU, F3_REMU});
  assign sb    = iFunct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  assign neg_a = sa & iA[XLEN-1];
  assign neg_b = sb & iB[XLEN-1];

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.val_i(iA), .neg_i(neg_a), .val_o(mag_a));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.val_i(iB), .neg_i(neg_b), .val_o(mag_b));

  assign b_zero = (iB == '0);
  assign sovf   = (iFunct3 inside {F3_DIV, F3_REM}) &&
                  (iA == {1'b1, {(XLEN-1){1'b0}}}) && (iB == '1);
  assign fast   = is_div(iFunct3) && (b_zero || sovf);

  always_comb begin
    fast_res = '0;
    if (b_zero) fast_res = is_rem(iFunct3) ? iA : '1;
    else        fast_res = is_rem(iFunct3) ? '0 : iA;
  end

  // Quotient sign is suppressed for B=0 so the full iteration (all-ones
  // quotient) matches the architectural divide-by-zero result.
  always_comb begin
    start_neg = neg_a ^ neg_b;
    if (is_div(iFunct3)) begin
      if (is_rem(iFunct3)) start_neg = neg_a;
      else                 start_neg = (neg_a ^ neg_b) & !b_zero;
    end
  end

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = '0;
    shifted = {hi_q, lo_q[XLEN-1]};
    if (is_div(f3_q)) begin
      if (shifted >= {1'b0, opr_q}) begin
        hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]} - opr_q;
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opr_q} : '0);
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    if (is_div(f3_q)) fix_in = {{XLEN{1'b0}}, is_rem(f3_q) ? hi_d : lo_d};
    else              fix_in = {hi_d, lo_d};
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_res (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

  assign res_d = (is_div(f3_q) || f3_q == F3_MUL) ? fix_out[XLEN-1:0]
                                                  : fix_out[2*XLEN-1:XLEN];

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      opr_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (iStart && !iKill) begin
            f3_q  <= iFunct3;
            opr_q <= is_div(iFunct3) ? mag_b : mag_a;
            lo_q  <= is_div(iFunct3) ? mag_a : mag_b;
            hi_q  <= '0;
            neg_q <= start_neg;
            cnt_q <= CW'(XLEN);
            if (EARLY_OUT && fast) begin
              result_q <= fast_res;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (iKill) begin
            state_q <= S_IDLE;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              result_q <= res_d;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oResult = result_q;
  assign oValid  = valid_q;
  assign oBusy   = (state_q != S_IDLE);
  assign oStall  = (iStart && (state_q == S_IDLE) && !iKill) || (state_q == S_RUN);

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: EARLY_OUT=1 and EARLY_OUT=0 instances
// share stimulus; results come from a table and an arithmetic reference model.
module tb_muldiv_iter;

  logic        clk, rst, start, kill;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic [31:0] res1, res0;
  logic        val1, val0, busy1, busy0, stall1, stall0;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res = '0;

  muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut1 (
    .iCLK(clk), .iRST(rst), .iStart(start), .iFunct3(f3), .iA(a), .iB(b),
    .iKill(kill), .oResult(res1), .oValid(val1), .oBusy(busy1), .oStall(stall1));

  muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut0 (
    .iCLK(clk), .iRST(rst), .iStart(start), .iFunct3(f3), .iA(a), .iB(b),
    .iKill(kill), .oResult(res0), .oValid(val0), .oBusy(busy0), .oStall(stall0));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, p;
    logic [63:0] bits;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    bits = '0;
    case (op)
      3'd0: begin bits = {32'h0, x} * {32'h0, y}; return bits[31:0]; end
      3'd1: begin p = sx * sy; bits = p; return bits[63:32]; end
      3'd2: begin p = sx * longint'({32'h0, y}); bits = p; return bits[63:32]; end
      3'd3: begin bits = {32'h0, x} * {32'h0, y}; return bits[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        p = sx / sy; bits = p; return bits[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        p = sx % sy; bits = p; return bits[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    return op[2] && (y == 0 || ((op == 3'd4 || op == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF));
  endfunction

  // Entered just after a negedge; leaves just after a negedge.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int kill_at);
    int lat1, lat0, nv1, nv0, elat1;
    logic [31:0] r1, r0;
    lat1 = 0; lat0 = 0; nv1 = 0; nv0 = 0; r1 = '0; r0 = '0;
    elat1 = is_fast(op, x, y) ? 1 : 33;
    f3 = op; a = x; b = y; start = 1'b1;
    #1;
    check({nm, " stall_start1"}, stall1, 1);
    check({nm, " stall_start0"}, stall0, 1);
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (val1) begin nv1++; if (lat1 == 0) begin lat1 = k; r1 = res1; end end
      if (val0) begin nv0++; if (lat0 == 0) begin lat0 = k; r0 = res0; end end
      if (k == 1 && kill_at == 0) check({nm, " stall_run0"}, stall0, 1);
      if (k == 33 && kill_at == 0) check({nm, " stall_done0"}, stall0, 0);
      if (k == 1) begin
        start = 1'b0; a = $urandom; b = $urandom; f3 = 3'($urandom_range(0, 7));
      end
      if (kill_at > 0 && k == kill_at) kill = 1'b1;
      if (kill_at > 0 && k == kill_at + 1) begin
        check({nm, " busy_after_kill1"}, busy1, 0);
        check({nm, " busy_after_kill0"}, busy0, 0);
        check({nm, " res_kept1"}, res1, last_res);
        check({nm, " res_kept0"}, res0, last_res);
        check({nm, " no_valid1"}, nv1, 0);
        check({nm, " no_valid0"}, nv0, 0);
        kill = 1'b0;
        break;
      end
    end
    if (kill_at == 0) begin
      check({nm, " result1"}, r1, exp);
      check({nm, " latency1"}, lat1, elat1);
      check({nm, " pulses1"}, nv1, 1);
      check({nm, " result0"}, r0, exp);
      check({nm, " latency0"}, lat0, 33);
      check({nm, " pulses0"}, nv0, 1);
      check({nm, " held1"}, res1, exp);
      check({nm, " held0"}, res0, exp);
      last_res = exp;
    end
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{"mul_7x-3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{"mulh_min",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{"mulhu_ones",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{"mulhsu_ones",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{"div_-7/2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{"rem_-7/2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{"divu_100/7",   3'd5, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{"remu_100/7",   3'd7, 32'd100,      32'd7,        32'd2};
    vecs[8]  = '{"div_5/0",      3'd4, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{"rem_5/0",      3'd6, 32'd5,        32'd0,        32'd5};
    vecs[10] = '{"div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{"rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{"div_-5/0",     3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF};
    vecs[13] = '{"rem_-5/0",     3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};

    clk = 1'b0; rst = 1'b1; start = 1'b0; kill = 1'b0; f3 = '0; a = '0; b = '0;
    #2;
    check("reset_result1", res1, 0);
    check("reset_valid1", val1, 0);
    check("reset_busy1", busy1, 0);
    check("reset_result0", res0, 0);
    check("reset_busy0", busy0, 0);
    check("reset_stall0", stall0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

    // Kill on the 10th RUN cycle, then an immediate restart.
    run_op("kill", 3'd0, 32'd5, 32'd6, 32'd0, 10);
    run_op("after_kill", 3'd0, 32'd5, 32'd6, 32'd30, 0);

    // iStart held high across DONE: one pulse, restart only from IDLE.
    begin
      int nv, lat_a, lat_b;
      nv = 0; lat_a = 0; lat_b = 0;
      f3 = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 75; k++) begin
        @(negedge clk);
        if (val0) begin nv++; if (lat_a == 0) lat_a = k; else if (lat_b == 0) lat_b = k; end
        if (k == 33) check("hold result0", res0, 81);
        if (k == 34) begin
          check("hold idle_busy0", busy0, 0);
          check("hold idle_busy1", busy1, 0);
          check("hold no_repeat0", val0, 0);
        end
        if (k == 35) begin
          check("hold restart0", busy0, 1);
          start = 1'b0;
        end
      end
      check("hold pulses0", nv, 2);
      check("hold first_lat0", lat_a, 33);
      check("hold second_lat0", lat_b, 67);
      last_res = 32'd81;
    end

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  op;
      logic [31:0] x, y;
      op = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'd1;
        3: y = 32'($urandom_range(1, 15));
        4: x = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", n, op), op, x, y, ref_op(op, x, y), 0);
    end

    // Asynchronous reset mid-RUN.
    f3 = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst busy0", busy0, 1);
    #2 rst = 1'b1;
    #1;
    check("arst busy1", busy1, 0);
    check("arst busy0", busy0, 0);
    check("arst valid0", val0, 0);
    check("arst result1", res1, 0);
    check("arst result0", res0, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst busy0", busy0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
